// File: rtl/eeg_aram_bank_rsp_pkg.sv
// eeg_aram_bank_rsp_pkg: shared types for the ARAM bank responder.
// FSM state enum and response FIFO entry width helpers.
package eeg_aram_bank_rsp_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BURST,
        ST_DRAIN
    } rsp_state_e;

    localparam int ARAM_DAT_DW_DFLT = 4;
    localparam int RSP_ENT_XW       = 2;

    // Entry = {END, LST, data}
    function automatic int rsp_ent_w(input int dw);
        return dw + RSP_ENT_XW;
    endfunction

    localparam int RSP_ENT_W = ARAM_DAT_DW_DFLT + RSP_ENT_XW;

endpackage

// File: rtl/eeg_aram_bank_rsp_fifo.sv
// eeg_aram_bank_rsp_fifo: small synchronous FIFO for read responses.
// Head word is visible combinationally; push when full / pop when empty are ignored.
module eeg_aram_bank_rsp_fifo #(
    parameter int DATA_WIDTH = 6,
    parameter int ADDR_WIDTH = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push_i,
    input  logic [DATA_WIDTH-1:0] wdat_i,
    input  logic                  pop_i,
    output logic [DATA_WIDTH-1:0] rdat_o,
    output logic                  empty_o
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [ADDR_WIDTH:0]   wptr_q, rptr_q;
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic                  full, do_push, do_pop;

    assign empty_o = (wptr_q == rptr_q);
    assign full    = (wptr_q[ADDR_WIDTH] != rptr_q[ADDR_WIDTH]) &&
                     (wptr_q[ADDR_WIDTH-1:0] == rptr_q[ADDR_WIDTH-1:0]);
    assign do_push = push_i & ~full;
    assign do_pop  = pop_i & ~empty_o;
    assign rdat_o  = mem_q[rptr_q[ADDR_WIDTH-1:0]];

    // Pointer update; extra MSB distinguishes full from empty
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            if (do_push) wptr_q <= wptr_q + 1'b1;
            if (do_pop)  rptr_q <= rptr_q + 1'b1;
        end
    end

    // Storage array; contents are only observed through valid entries
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wptr_q[ADDR_WIDTH-1:0]] <= wdat_i;
    end

endmodule

// File: rtl/eeg_aram_bank_rsp.sv
// eeg_aram_bank_rsp: ARAM bank-side read responder (address stream -> data stream).
// Optional ARAM_RSP_STAT_EN adds RSP_BEAT_CNT, a wrapping count of delivered beats.
module eeg_aram_bank_rsp
    import eeg_aram_bank_rsp_pkg::*;
#(
    parameter int ARAM_ADD_AW = 12,
    parameter int ARAM_DAT_DW = 4,
    parameter int RSP_BUF_AW  = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   AARB_ADD_VLD,
    input  logic                   AARB_ADD_LST,
    input  logic                   AARB_ADD_END,
    output logic                   AARB_ADD_RDY,
    input  logic [ARAM_ADD_AW-1:0] AARB_ADD_ADD,
    output logic                   AARB_DAT_VLD,
    output logic                   AARB_DAT_LST,
    input  logic                   AARB_DAT_RDY,
    output logic [ARAM_DAT_DW-1:0] AARB_DAT_DAT,
    output logic                   ARAM_RAM_REN,
    output logic [ARAM_ADD_AW-1:0] ARAM_RAM_ADD,
    input  logic [ARAM_DAT_DW-1:0] ARAM_RAM_DAT,
    output logic                   RSP_DONE
`ifdef ARAM_RSP_STAT_EN
    ,
    output logic [15:0]            RSP_BEAT_CNT
`endif
);

    localparam int DEPTH = 1 << RSP_BUF_AW;
    localparam int EW    = rsp_ent_w(ARAM_DAT_DW);
    localparam logic [RSP_BUF_AW:0] CNT_FULL = (RSP_BUF_AW + 1)'(DEPTH);

    rsp_state_e            state_q, state_d;
    logic [RSP_BUF_AW:0]   cnt_q, cnt_d;
    logic                  dly_vld_q, dly_lst_q, dly_end_q;
    logic                  fifo_empty;
    logic [EW-1:0]         head;
    logic                  add_ena, dat_ena, dat_vld;

    assign dat_vld = ~fifo_empty;
    assign dat_ena = dat_vld & AARB_DAT_RDY;
    assign add_ena = AARB_ADD_VLD & AARB_ADD_RDY;

    // A pop in this cycle frees a slot, so DAT_RDY feeds ADD_RDY directly
    assign AARB_ADD_RDY = (state_q != ST_DRAIN) &
                          ((cnt_q < CNT_FULL) | dat_ena);

    assign ARAM_RAM_REN = add_ena;
    assign ARAM_RAM_ADD = AARB_ADD_ADD;

    assign AARB_DAT_VLD = dat_vld;
    assign AARB_DAT_DAT = dat_vld ? head[ARAM_DAT_DW-1:0] : '0;
    assign AARB_DAT_LST = dat_vld & head[ARAM_DAT_DW];
    assign RSP_DONE     = dat_ena & head[ARAM_DAT_DW+1];

    // Outstanding beats: in the SRAM stage plus buffered in the FIFO
    always_comb begin
        cnt_d = cnt_q;
        unique case (1'b1)
            add_ena & ~dat_ena: cnt_d = cnt_q + 1'b1;
            ~add_ena & dat_ena: cnt_d = cnt_q - 1'b1;
            default:            cnt_d = cnt_q;
        endcase
    end

    // Burst serialisation; leave DRAIN as soon as the last beat pops
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:
                if (add_ena) state_d = AARB_ADD_LST ? ST_DRAIN : ST_BURST;
            ST_BURST:
                if (add_ena && AARB_ADD_LST) state_d = ST_DRAIN;
            ST_DRAIN:
                if (cnt_d == '0) state_d = ST_IDLE;
            default:
                state_d = ST_IDLE;
        endcase
    end

    // State, counter and the flag delay stage matching SRAM latency
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            dly_vld_q <= 1'b0;
            dly_lst_q <= 1'b0;
            dly_end_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            dly_vld_q <= add_ena;
            dly_lst_q <= add_ena & AARB_ADD_LST;
            dly_end_q <= add_ena & AARB_ADD_END;
        end
    end

    eeg_aram_bank_rsp_fifo #(
        .DATA_WIDTH (EW),
        .ADDR_WIDTH (RSP_BUF_AW)
    ) u_rsp_buf (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (dly_vld_q),
        .wdat_i  ({dly_end_q, dly_lst_q, ARAM_RAM_DAT}),
        .pop_i   (dat_ena),
        .rdat_o  (head),
        .empty_o (fifo_empty)
    );

`ifdef ARAM_RSP_STAT_EN
    logic [15:0] beat_cnt_q;

    // Delivered-beat statistic, wraps naturally at 16 bits
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) beat_cnt_q <= '0;
        else if (dat_ena) beat_cnt_q <= beat_cnt_q + 16'd1;
    end

    assign RSP_BEAT_CNT = beat_cnt_q;
`endif

endmodule

// File: doc/eeg_aram_bank_rsp.md
# eeg_aram_bank_rsp

Bank-side responder for the activation-RAM (ARAM) read path: one instance per ARAM bank, it terminates the arbitrated address stream (AARB_ADD_*) that the ARAM router forwards and answers it with the AARB_DAT_* read-data stream. It issues reads to a single-port SRAM with 1-cycle read latency. Results are held in a small response FIFO so downstream backpressure never loses data. Bursts are serialised: a new burst is not accepted until the previous one has fully drained.

## Interface
- ARAM_ADD_AW, 12, SRAM word address width
- ARAM_DAT_DW, 4, data word width
- RSP_BUF_AW, 1, log2 of response FIFO depth (DEPTH = 2**RSP_BUF_AW, min 2)

- clk  in  1  clock; the only clock
- rst_n  in  1  asynchronous, active-low reset
- AARB_ADD_VLD  in  1  address beat valid
- AARB_ADD_LST  in  1  last address beat of burst
- AARB_ADD_END  in  1  beat closes the requester session
- AARB_ADD_RDY  out  1  address beat accepted when VLD&RDY
- AARB_ADD_ADD  in  ARAM_ADD_AW  read address
- AARB_DAT_VLD  out  1  read-data valid
- AARB_DAT_LST  out  1  data beat matching an LST address beat
- AARB_DAT_RDY  in  1  downstream ready
- AARB_DAT_DAT  out  ARAM_DAT_DW  read data
- ARAM_RAM_REN  out  1  SRAM read enable, active-high
- ARAM_RAM_ADD  out  ARAM_ADD_AW  SRAM address
- ARAM_RAM_DAT  in  ARAM_DAT_DW  SRAM read data, valid the cycle after REN
- RSP_DONE  out  1  one-cycle pulse when the END-tagged beat is delivered

## Operation
- add_ena = VLD&RDY; dat_ena = DAT_VLD&DAT_RDY.
- ARAM_RAM_REN = add_ena; ARAM_RAM_ADD = AARB_ADD_ADD (combinational pass-through).
- The LST and END flags of each accepted beat go through a 1-cycle delay stage alongside the SRAM access. In the next cycle, {END, LST, ARAM_RAM_DAT} is written into the FIFO.
- The FIFO head drives DAT_DAT/DAT_LST. DAT_VLD = ~fifo_empty.
- Outstanding counter `out_cnt`, width RSP_BUF_AW+1:
  - +1 on add_ena, −1 on dat_ena; both together leave it unchanged.
  - It counts in-flight plus buffered beats and never exceeds DEPTH.
- FSM states:
  - IDLE: add_ena with LST → DRAIN; add_ena without LST → BURST.
  - BURST: add_ena with LST → DRAIN.
  - DRAIN: ADD_RDY = 0; when out_cnt reaches 0 → IDLE.
- AARB_ADD_RDY = (state != DRAIN) & ((out_cnt < DEPTH) | dat_ena). This is a combinational path from DAT_RDY to ADD_RDY, and it is intentional.
- RSP_DONE = dat_ena & head END bit.
- END without LST is legal: it is only tagged, and does not change state.

## Timing
- Reset values:
  - state IDLE, out_cnt 0, FIFO empty, delay stage cleared.
  - DAT_VLD 0, DAT_LST 0, DAT_DAT 0, RSP_DONE 0, RAM_REN 0.
  - ADD_RDY 1 after reset release.
- Latency:
  - Address accepted in cycle t → SRAM data sampled at the end of t+1 → DAT_VLD high in t+2.
- Throughput: 1 beat/cycle sustained for any DEPTH ≥ 2 while DAT_RDY stays high.
- FIFO full is impossible by construction, because the out_cnt gate counts in-flight beats. Asserting DAT_RDY while empty has no effect.
- DAT_VLD/DAT_LST/DAT_DAT stay stable while DAT_VLD & ~DAT_RDY.
- Reset asserted mid-burst: the in-flight SRAM beat is discarded, all state is cleared immediately (async), and no data beat is emitted afterwards.

## Configuration
- ARAM_RSP_STAT_EN:
  - Defined: adds output RSP_BEAT_CNT[15:0], which counts dat_ena beats, wraps at 16'hFFFF→0, and resets to 0.
  - Undefined: the port and counter do not exist. Behaviour is otherwise identical.

## Structure
- Shared EEG package: the FSM state enum (IDLE/BURST/DRAIN) and the FIFO entry width localparam ARAM_DAT_DW+2.
- Sub-module: the response buffer reuses CPM_FIFO (DATA_WIDTH=ARAM_DAT_DW+2, ADDR_WIDTH=RSP_BUF_AW). Everything else is in-line.

## Test plan
- Single-beat burst: addr 0x010 (LST=1, END=1), SRAM word 0xA → DAT_VLD in t+2 with DAT 0xA, LST=1, RSP_DONE pulse; ADD_RDY low until the beat pops.
- 8-beat burst at addresses 0x100–0x107 with DAT_RDY=1 → 8 consecutive data beats, in order, LST only on the 8th; no bubbles.
- Backpressure: DAT_RDY=0 for 5 cycles during a burst with DEPTH=2 → ADD_RDY drops once out_cnt=2; no beat lost or duplicated; data is held stable.
- Serialisation: a second burst is presented while the first is in DRAIN → its first beat is accepted only in the cycle after the last data beat of the first burst pops.
- Reset mid-burst after 3 accepts → outputs return to reset values; a following 2-beat burst returns only its own 2 beats.
- With ARAM_RSP_STAT_EN: 20 beats delivered → RSP_BEAT_CNT = 20; preload near wrap → the counter wraps to 0.
